// File: rtl/morse_sequencer_if.sv
// Character/converter/keying signal bundle for the Morse sequencer.
// The master side is the character source plus the ASCII-to-Morse converter.
// The slave side is the sequencer itself.
interface morse_sequencer_if;
    logic       char_valid;
    logic [6:0] char_in;
    logic       char_ready;
    logic [6:0] ascii_code;
    logic [6:0] morse_code;
    logic [2:0] morse_len;
    logic       key_out;
    logic       busy;

    modport master (
        output char_valid, char_in, morse_code, morse_len,
        input  char_ready, ascii_code, key_out, busy
    );

    modport slave (
        input  char_valid, char_in, morse_code, morse_len,
        output char_ready, ascii_code, key_out, busy
    );
endinterface

// File: rtl/morse_sequencer.sv
// Morse character sequencer.
// Accepts one ASCII character, waits out the converter's registered lookup,
// then keys the dots and dashes with standard unit timing. A trailing gap
// follows every character, and a word gap follows a space.
module morse_sequencer #(
    parameter int unsigned UNIT_CYCLES = 2400000
) (
    input  logic              clk_24,
    input  logic              rst_n,
    morse_sequencer_if.slave  bus
);

    localparam int unsigned CYC_W = $clog2(UNIT_CYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MARK,
        SPACE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic             key_out_q, key_out_d;
    logic [6:0]       ascii_q, ascii_d;
    logic             lk_q, lk_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [1:0]       unit_q, unit_d;
    logic [6:0]       code_q, code_d;
    logic [2:0]       len_q, len_d;
    logic [2:0]       idx_q, idx_d;

    logic             timed;
    logic             expired;
    logic [3:0]       idx_nxt;

    // A timed state ends once both the cycle and the unit counter are at terminal count.
    assign timed   = (state_q == MARK) || (state_q == SPACE) || (state_q == GAP);
    assign expired = (cyc_q == CYC_LAST) && (unit_q == 2'd0);
    assign idx_nxt = {1'b0, idx_q} + 4'd1;

    // Next-state logic: handshake, lookup wait, element sequencing and unit counting.
    always_comb begin
        state_d = state_q;
        ascii_d = ascii_q;
        lk_d    = lk_q;
        cyc_d   = cyc_q;
        unit_d  = unit_q;
        code_d  = code_q;
        len_d   = len_q;
        idx_d   = idx_q;

        // Free-running unit timer; state entries below override it with a reload.
        if (timed) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d  = '0;
                unit_d = unit_q - 2'd1;
            end else begin
                cyc_d  = cyc_q + CYC_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.char_valid) begin
                    ascii_d = bus.char_in;
                    lk_d    = 1'b0;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                // Second LOOKUP cycle sees the converter's registered result.
                if (!lk_q) begin
                    lk_d = 1'b1;
                end else begin
                    code_d = bus.morse_code;
                    len_d  = bus.morse_len;
                    idx_d  = 3'd0;
                    cyc_d  = '0;
                    if ((ascii_q == 7'd32) || (bus.morse_len == 3'd7)) begin
                        // 4 units here plus the previous character's 3-unit gap make a word gap.
                        state_d = GAP;
                        unit_d  = 2'd3;
                    end else if (bus.morse_len == 3'd0) begin
                        state_d = IDLE;
                        unit_d  = 2'd0;
                    end else begin
                        state_d = MARK;
                        unit_d  = bus.morse_code[0] ? 2'd2 : 2'd0;
                    end
                end
            end

            MARK: begin
                if (expired) begin
                    cyc_d = '0;
                    if (idx_nxt < {1'b0, len_q}) begin
                        state_d = SPACE;
                        unit_d  = 2'd0;
                        idx_d   = idx_nxt[2:0];
                    end else begin
                        state_d = GAP;
                        unit_d  = 2'd2;
                    end
                end
            end

            SPACE: begin
                if (expired) begin
                    state_d = MARK;
                    cyc_d   = '0;
                    unit_d  = code_q[idx_q] ? 2'd2 : 2'd0;
                end
            end

            GAP: begin
                if (expired) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Key is registered so it rises on the same edge that enters MARK.
        key_out_d = (state_d == MARK);
    end

    // State and datapath registers; reset drops the key line without a clock.
    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_out_q <= 1'b0;
            ascii_q   <= 7'd0;
            lk_q      <= 1'b0;
            cyc_q     <= '0;
            unit_q    <= 2'd0;
            code_q    <= 7'd0;
            len_q     <= 3'd0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            key_out_q <= key_out_d;
            ascii_q   <= ascii_d;
            lk_q      <= lk_d;
            cyc_q     <= cyc_d;
            unit_q    <= unit_d;
            code_q    <= code_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.char_ready = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.key_out    = key_out_q;
    assign bus.ascii_code = ascii_q;

endmodule
